// File: rtl/ps2_host_transmitter.sv
// rtl/ps2_host_transmitter.sv - PS/2 host-to-device command byte serialiser with ack/timeout reporting
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err_ack,
    output logic       err_timeout
);

    localparam int MAXC0 = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int MAXC  = (MAXC0 > TIMEOUT_CYCLES) ? MAXC0 : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_REL, S_BITS, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    shift_q, shift_d;
    logic          ok_q, ok_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          err_ack_q, err_ack_d;
    logic          err_to_q, err_to_d;
    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          data_meta_q, data_sync_q;
    logic          fall;
    logic          timing;

    assign fall = clk_prev_q & ~clk_sync_q;

    // Synchronisers start at the idle (high) bus level so reset never fakes a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            ok_q        <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            err_ack_q   <= 1'b0;
            err_to_q    <= 1'b0;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ok_q        <= ok_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            err_ack_q   <= err_ack_d;
            err_to_q    <= err_to_d;
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        ok_d      = ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_ack_d = 1'b0;
        err_to_d  = 1'b0;
        timing    = (state_q inside {S_REL, S_BITS, S_ACK, S_WAIT_IDLE});

        if (timing) begin
            cnt_d = fall ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shift_d  = {~^tx_data, tx_data};
                    ok_d     = 1'b0;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_START: begin
                if (cnt_q == CW'(START_CYCLES - 1)) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = S_REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REL: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = S_BITS;
            end
            S_BITS: begin
                // Falls 1-9 present data then parity; fall 10 releases the line as the stop bit.
                if (fall) begin
                    if (bit_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                        bit_d     = bit_q + 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (!data_sync_q) ok_d = 1'b1;
                    else              err_ack_d = 1'b1;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    done_d  = ok_q;
                    ok_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timing && !fall && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            ok_d      = 1'b0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_ack_d = 1'b0;
            err_to_d  = 1'b1;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err_ack     = err_ack_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// tb/tb_ps2_host_transmitter.sv - randomized scoreboard bench with a PS/2 device model
module tb_ps2_host_transmitter;

    localparam int INH  = 16;
    localparam int STC  = 4;
    localparam int TO   = 200;
    localparam int HALF = 20;

    typedef struct {
        int         kind;   // 0 done, 1 err_ack, 2 err_timeout
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, err_ack, err_timeout;
    logic       dev_clk = 1'b1;
    logic       dev_data_low = 1'b0;
    logic       line_clk, line_data;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    exp_t       exp_q[$];

    int         dev_nfalls = 11;
    bit         dev_ack = 1'b1;
    bit         dev_abort = 1'b0;
    int         dev_falls = 0;
    int         dev_last_fall = 0;
    logic [9:0] dev_frame = '0;

    int         inh_run = 0;
    int         st_run = 0;

    assign line_clk  = ~ps2_clk_oe & dev_clk;
    assign line_data = ~ps2_data_oe & ~dev_data_low;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INH),
        .START_CYCLES  (STC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_in (line_clk),
        .ps2_data_in(line_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .err_ack    (err_ack),
        .err_timeout(err_timeout)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line levels the device should see: data LSB first, odd parity, released stop bit.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    task automatic dev_wait(input int n);
        for (int k = 0; k < n && !dev_abort; k++) @(negedge clk);
    endtask

    task automatic wait_ready(input int max);
        int k;
        k = 0;
        while (!tx_ready && k < max) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) chk("ready_wait_expired", 0, 1);
    endtask

    task automatic send(input logic [7:0] b, input int kind, input int nfalls, input bit ack);
        wait_ready(3000);
        dev_nfalls = nfalls;
        dev_ack    = ack;
        tx_valid   = 1'b1;
        tx_data    = b;
        exp_q.push_back('{kind, b});
        @(negedge clk);
        tx_valid = 1'b0;
        chk("ready_drop", tx_ready, 0);
        chk("busy_set", busy, 1);
        wait_ready(3000);
        repeat (5) @(negedge clk);
    endtask

    // Device model: answers a request-to-send by clocking the frame and optionally acking.
    initial begin
        forever begin
            dev_clk      = 1'b1;
            dev_data_low = 1'b0;
            @(negedge clk);
            while (dev_abort || !ps2_clk_oe) @(negedge clk);
            while (!dev_abort && ps2_clk_oe) @(negedge clk);
            if (!dev_abort) begin
                dev_falls = 0;
                dev_wait(10);
                for (int i = 1; i <= dev_nfalls && !dev_abort; i++) begin
                    dev_clk       = 1'b0;
                    dev_falls     = i;
                    dev_last_fall = cyc;
                    dev_wait(HALF);
                    if (i <= 10) dev_frame[i-1] = line_data;
                    dev_clk = 1'b1;
                    if (i == 10 && dev_ack) dev_data_low = 1'b1;
                    dev_wait(HALF);
                end
                dev_data_low = 1'b0;
            end
        end
    end

    // Monitor: line timing and outcome scoreboard.
    initial begin
        exp_t e;
        int   act;
        int   lat;
        forever begin
            @(negedge clk);
            if (rst) begin
                inh_run = 0;
                st_run  = 0;
            end else begin
                if (ps2_clk_oe && !ps2_data_oe) begin
                    inh_run++;
                end else if (ps2_clk_oe && ps2_data_oe) begin
                    if (st_run == 0) chk("inhibit_len", inh_run, INH);
                    st_run++;
                end else begin
                    if (st_run > 0) begin
                        chk("start_len", st_run, STC);
                        chk("start_bit_held", ps2_data_oe, 1);
                    end
                    inh_run = 0;
                    st_run  = 0;
                end

                if (done || err_ack || err_timeout) begin
                    chk("pulse_onehot", int'(done) + int'(err_ack) + int'(err_timeout), 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", 1, 0);
                    end else begin
                        e   = exp_q.pop_front();
                        act = done ? 0 : (err_ack ? 1 : 2);
                        chk("outcome", act, e.kind);
                        if (e.kind != 2) begin
                            chk("frame", dev_frame, frame_of(e.data));
                        end else begin
                            lat = cyc - dev_last_fall;
                            chk("timeout_latency_in_window", (lat >= TO && lat <= TO + 10) ? 1 : 0, 1);
                            chk("timeout_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
                            chk("timeout_ready", tx_ready, 1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        logic [7:0] b;
        bit ack;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {done, err_ack, err_timeout}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send(8'hED, 0, 11, 1'b1);
        send(8'h00, 0, 11, 1'b1);
        send(8'h01, 0, 11, 1'b1);
        send(8'($urandom), 1, 11, 1'b0);
        send(8'($urandom), 2, 4, 1'b1);

        // Held tx_valid with new data mid-transfer must wait for tx_ready.
        wait_ready(3000);
        dev_nfalls = 11;
        dev_ack    = 1'b1;
        tx_valid   = 1'b1;
        tx_data    = 8'hED;
        exp_q.push_back('{0, 8'hED});
        @(negedge clk);
        chk("hs_ready_drop", tx_ready, 0);
        repeat (30) @(negedge clk);
        tx_data = 8'h07;
        exp_q.push_back('{0, 8'h07});
        chk("hs_still_busy", tx_ready, 0);
        wait_ready(3000);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("hs_second_accept", tx_ready, 0);
        wait_ready(3000);
        repeat (5) @(negedge clk);

        // Reset in the middle of the data bits.
        wait_ready(3000);
        dev_nfalls = 11;
        dev_ack    = 1'b1;
        tx_valid   = 1'b1;
        tx_data    = 8'($urandom);
        @(negedge clk);
        tx_valid = 1'b0;
        k = 0;
        while (dev_falls != 5 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("reached_fall5", dev_falls, 5);
        repeat (8) @(negedge clk);
        chk("mid_bits_busy", busy, 1);
        dev_abort = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_clk_oe", ps2_clk_oe, 0);
        chk("midrst_data_oe", ps2_data_oe, 0);
        chk("midrst_tx_ready", tx_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_pulses", {done, err_ack, err_timeout}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        dev_abort = 1'b0;
        repeat (5) @(negedge clk);
        send(8'hFF, 0, 11, 1'b1);

        for (int i = 0; i < 6; i++) begin
            b   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            send(b, ack ? 0 : 1, 11, ack);
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
